// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching instruction-fetch front end.
package fetch_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & {{(PC_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fetch_unit_chk.sv
// Protocol checks for the fetch unit: no response without an outstanding request, no FIFO overflow.
module prefetch_fetch_unit_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic             mem_rsp_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic             push,
    input logic             full
);

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !full);

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy update; flush empties the FIFO regardless of push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch front end: credit-limited sequential requests, in-order responses, redirect flush.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             run_q;
    logic             busy_q, busy_d;

    logic             req_fire_s, rsp_fire_s, push_s, pop_s, credit_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [XLEN-1:0]  redir_pc_s;
    fetch_entry_t     entry_in_s, head_s;

    // Buffered words plus in-flight requests never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_s      = ({1'b0, fifo_count_s} + {1'b0, outstanding_q}) < SUM_W'(DEPTH);
    assign mem_req_valid = run_q && credit_s && !redirect_valid;
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire_s    = mem_req_valid && mem_req_ready;
    assign rsp_fire_s    = mem_rsp_valid && (outstanding_q != '0);
    assign redir_pc_s    = XLEN'(align_pc(PC_W'(redirect_pc)));
    assign entry_in_s    = {PC_W'(rsp_pc_q), mem_rsp_data};

    assign instr_valid = !fifo_empty_s;
    assign instr_out   = instr_valid ? head_s.instr : 32'h0000_0000;
    assign instr_pc    = instr_valid ? XLEN'(head_s.pc) : '0;
    assign pop_s       = instr_valid && instr_ready;
    assign busy        = busy_q;

    // Next-state for PCs and counters; a redirect makes every in-flight response a drop.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        push_s        = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(req_fire_s) - CNT_W'(rsp_fire_s);
        if (redirect_valid) begin
            fetch_pc_d = redir_pc_s;
            rsp_pc_d   = redir_pc_s;
            drop_d     = outstanding_d;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_fire_s && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end else if (rsp_fire_s) begin
                push_s   = 1'b1;
                rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
            end else begin
                drop_d = drop_q;
            end
        end
        busy_d = (outstanding_d != '0) || (drop_d != '0);
    end

    // State registers; run_q keeps requests quiet until the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            run_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            run_q         <= 1'b1;
            busy_q        <= busy_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata (entry_in_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    prefetch_fetch_unit_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rsp_valid (mem_rsp_valid),
        .outstanding   (outstanding_q),
        .push          (push_s),
        .full          (fifo_full_s)
    );

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit with an in-order memory model and a consumer log.
module tb_prefetch_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    logic        rsp_hold;
    logic [31:0] pend [$];
    logic [31:0] acc  [$];
    logic [63:0] got  [$];
    int          total = 0;
    int          bad   = 0;
    int          n0;

    always #5 clk = ~clk;

    prefetch_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Log accepted requests and delivered instructions.
    always @(posedge clk) begin
        if (rst_n && mem_req_valid && mem_req_ready) begin
            acc.push_back(mem_req_addr);
            pend.push_back(mem_req_addr);
        end
        if (rst_n && instr_valid && instr_ready) begin
            got.push_back({instr_pc, instr_out});
        end
    end

    // One-cycle in-order memory: answer the oldest accepted request unless held.
    always @(negedge clk) begin
        logic [31:0] a;
        if (!rst_n || rsp_hold || pend.size() == 0) begin
            mem_rsp_valid = 1'b0;
        end else begin
            a             = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(a);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check the cleared outputs, then release one cycle-edge later.
    task automatic do_reset();
        rst_n          = 1'b0;
        mem_req_ready  = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_hold       = 1'b0;
        #1;
        check_eq("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_eq("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        check_eq("rst_instr_out", {32'h0, instr_out}, 64'h0);
        check_eq("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        tick();
        pend.delete();
        acc.delete();
        got.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        // Streaming from RESET_PC with a 1-cycle memory.
        do_reset();
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;
        tick();
        check_eq("t1_first_addr", {32'h0, mem_req_addr}, 64'h0);
        check_eq("t1_first_valid", {63'h0, mem_req_valid}, 64'h1);
        tick();
        tick();
        check_eq("t1_first_instr_pc", {32'h0, instr_pc}, 64'h0);
        check_eq("t1_first_instr", {32'h0, instr_out}, 64'h0000_0000_C0DE_0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t1_stream_valid", {63'h0, instr_valid}, 64'h1);
        end
        check_eq("t1_acc3", {32'h0, acc_at(3)}, 64'h0000_000C);
        check_eq("t1_got0", got_at(0), 64'h0000_0000_C0DE_0000);
        check_eq("t1_got1", got_at(1), 64'h0000_0004_C0DE_0004);
        check_eq("t1_got3", got_at(3), 64'h0000_000C_C0DE_000C);

        // Back-pressure from the core: credits cap requests at DEPTH.
        do_reset();
        mem_req_ready = 1'b1;
        instr_ready   = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_acc_count", 64'(acc.size()), 64'd4);
        check_eq("t2_req_valid_low", {63'h0, mem_req_valid}, 64'h0);
        check_eq("t2_head_pc", {32'h0, instr_pc}, 64'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t2_head_after_pop", {32'h0, instr_pc}, 64'h4);
        for (int i = 0; i < 5; i++) tick();
        check_eq("t2_acc_count2", 64'(acc.size()), 64'd5);
        check_eq("t2_acc4", {32'h0, acc_at(4)}, 64'h10);
        check_eq("t2_req_valid_low2", {63'h0, mem_req_valid}, 64'h0);

        // Memory stall: the request address holds.
        do_reset();
        mem_req_ready = 1'b0;
        instr_ready   = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_addr_hold", {32'h0, mem_req_addr}, 64'h0);
            check_eq("t3_valid_hold", {63'h0, mem_req_valid}, 64'h1);
            check_eq("t3_no_instr", {63'h0, instr_valid}, 64'h0);
            tick();
        end
        check_eq("t3_no_accept", 64'(acc.size()), 64'd0);

        // Redirect with two requests in flight.
        do_reset();
        rsp_hold      = 1'b1;
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check_eq("t4_valid_forced_low", {63'h0, mem_req_valid}, 64'h0);
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_new_addr", {32'h0, mem_req_addr}, 64'h100);
        check_eq("t4_busy", {63'h0, busy}, 64'h1);
        rsp_hold = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t4_acc2", {32'h0, acc_at(2)}, 64'h100);
        check_eq("t4_got0", got_at(0), 64'h0000_0100_C0DE_0100);
        check_eq("t4_got1", got_at(1), 64'h0000_0104_C0DE_0104);

        // Redirect in a cycle where a response arrives.
        do_reset();
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check_eq("t5_busy_before", {63'h0, busy}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        n0 = got.size();
        check_eq("t5_busy_after", {63'h0, busy}, 64'h0);
        check_eq("t5_flushed", {63'h0, instr_valid}, 64'h0);
        check_eq("t5_new_addr", {32'h0, mem_req_addr}, 64'h200);
        for (int i = 0; i < 8; i++) tick();
        check_eq("t5_first", got_at(n0), 64'h0000_0200_C0DE_0200);
        check_eq("t5_count", 64'(got.size() - n0), 64'd6);
        for (int i = n0; i < got.size(); i++) begin
            check_eq("t5_no_stale_pc", {32'h0, got[i][63:32]}, {32'h0, 32'h200 + 32'(4 * (i - n0))});
        end

        // Address wrap at the top of the space.
        do_reset();
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_acc0", {32'h0, acc_at(0)}, 64'hFFFF_FFFC);
        check_eq("t6_acc1", {32'h0, acc_at(1)}, 64'h0);
        check_eq("t6_got0", got_at(0), 64'hFFFF_FFFC_3F21_FFFC);
        check_eq("t6_got1", got_at(1), 64'h0000_0000_C0DE_0000);
        check_eq("t6_got2", got_at(2), 64'h0000_0004_C0DE_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
